// File: rtl/ioctl_dl_sender.sv
// Streams a block of source bytes into an ioctl download port, one byte per
// fetch/write/gap round, with receiver back-pressure honoured during the gap.
module ioctl_dl_sender #(
  parameter int unsigned WR_GAP = 3
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  index,
  input  logic [24:0] length,
  output logic [24:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        ioctl_download,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_index,
  input  logic        ioctl_wait,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, GAP, FINISH} state_t;

  localparam logic [7:0] GAP_LAST = 8'(WR_GAP - 1);

  state_t      state;
  logic [24:0] len_r;
  logic [24:0] byte_cnt;
  logic [7:0]  gap_cnt;

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state          <= IDLE;
      len_r          <= '0;
      byte_cnt       <= '0;
      gap_cnt        <= '0;
      src_addr       <= '0;
      src_rd         <= 1'b0;
      ioctl_download <= 1'b0;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      ioctl_index    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      src_rd   <= 1'b0;
      ioctl_wr <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len_r       <= length;
          ioctl_index <= index;
          src_addr    <= '0;
          ioctl_addr  <= '0;
          byte_cnt    <= '0;
          busy        <= 1'b1;
          if (length == '0) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            src_rd         <= 1'b1;
            ioctl_download <= 1'b1;
            state          <= FETCH;
          end
        end
        FETCH: if (src_valid) begin
          ioctl_dout <= src_data;
          ioctl_wr   <= 1'b1;
          byte_cnt   <= byte_cnt + 25'd1;
          state      <= WRITE;
        end
        WRITE: begin
          gap_cnt <= '0;
          state   <= GAP;
        end
        // Gap counter only advances while the receiver is not stalling.
        GAP: if (!ioctl_wait) begin
          if (gap_cnt == GAP_LAST) begin
            if (byte_cnt != len_r) begin
              src_addr   <= src_addr + 25'd1;
              ioctl_addr <= ioctl_addr + 25'd1;
              src_rd     <= 1'b1;
              state      <= FETCH;
            end else begin
              ioctl_download <= 1'b0;
              done           <= 1'b1;
              state          <= FINISH;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_dl_sender.sv
// Directed bench: a transfer-level model checks every read, write and done
// event as it happens; directed tests pin timing with hand-computed cycles.
module tb_ioctl_dl_sender;

  logic        clk_48 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  index = '0;
  logic [24:0] length = '0;
  logic [24:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data = '0;
  logic        src_valid = 1'b0;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait = 1'b0;
  logic        busy;
  logic        done;

  ioctl_dl_sender #(.WR_GAP(3)) dut (
    .clk_48(clk_48), .reset(reset), .start(start), .index(index), .length(length),
    .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data), .src_valid(src_valid),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .busy(busy), .done(done)
  );

  initial forever #5 clk_48 = ~clk_48;

  int vec = 0, err = 0, cyc = 0;
  int rd_n = 0, wr_n = 0, done_n = 0, dl_n = 0;
  int rd_cyc[256], wr_cyc[256], done_cyc[256];
  logic [7:0] wr_data[256];
  int rd_x, wr_x, cur_len, cur_idx;
  int rd_b, wr_b, dn_b, dl_b, st, w;
  bit xfer_open = 0, pend = 0, inj = 0, allow_done = 1;
  logic [24:0] pend_addr;

  // Source byte content as a function of its offset.
  function automatic logic [7:0] f(input int a);
    return 8'((a * 37 + 92) & 255);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon();
    if (xfer_open && !done) chk("dl_held", ioctl_download, 1);
    if (ioctl_download) chk("busy_with_dl", busy, 1);
    if (src_rd) begin
      chk("rd_dl", ioctl_download, 1);
      chk("rd_addr", src_addr, rd_x);
      chk("rd_nowait", ioctl_wait, 0);
      if (rd_n < 256) rd_cyc[rd_n] = cyc;
      rd_n++; rd_x++;
      pend = 1; pend_addr = src_addr; xfer_open = 1;
    end
    if (ioctl_wr) begin
      chk("wr_dl", ioctl_download, 1);
      chk("wr_addr", ioctl_addr, wr_x);
      chk("wr_dout", ioctl_dout, f(wr_x));
      chk("wr_index", ioctl_index, cur_idx);
      chk("wr_in_range", wr_x < cur_len, 1);
      chk("wr_nowait", ioctl_wait, 0);
      if (wr_n < 256) begin wr_cyc[wr_n] = cyc; wr_data[wr_n] = ioctl_dout; end
      wr_n++; wr_x++;
    end
    if (done) begin
      if (!allow_done) chk("no_done_after_abort", done, 0);
      chk("done_dl_low", ioctl_download, 0);
      chk("done_count", wr_x, cur_len);
      if (done_n < 256) done_cyc[done_n] = cyc;
      done_n++;
      xfer_open = 0;
    end
    if (ioctl_download) dl_n++;
  endtask

  // One clock: check at the falling edge, then drive the source just after the rising edge.
  task automatic step();
    @(negedge clk_48);
    mon();
    @(posedge clk_48);
    #1;
    cyc++;
    src_valid = 1'b0;
    if (pend) begin
      src_valid = 1'b1; src_data = f(int'(pend_addr)); pend = 0;
    end else if (inj) begin
      src_valid = 1'b1; src_data = 8'hEE; inj = 0;
    end
  endtask

  task automatic go(input int idx, input int len);
    cur_idx = idx; cur_len = len; wr_x = 0; rd_x = 0;
    rd_b = rd_n; wr_b = wr_n; dn_b = done_n; dl_b = dl_n;
    index = 8'(idx); length = 25'(len); start = 1'b1; st = cyc;
    step();
    start = 1'b0; index = 8'hA5; length = 25'd7;
  endtask

  task automatic wait_wr(input int target, input int budget);
    int k = 0;
    while (wr_n < target && k < budget) begin step(); k++; end
    chk("wr_timeout", wr_n >= target, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_n < target && k < budget) begin step(); k++; end
    chk("done_timeout", done_n >= target, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_src_rd"}, src_rd, 0);
    chk({tag, "_download"}, ioctl_download, 0);
    chk({tag, "_wr"}, ioctl_wr, 0);
    chk({tag, "_addr"}, ioctl_addr, 0);
    chk({tag, "_dout"}, ioctl_dout, 0);
    chk({tag, "_index"}, ioctl_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    step(); step();
    chk_zero("reset");
    reset = 1'b0;
    step();

    // Basic 4-byte transfer, with a stray src_valid injected during the gap.
    go(8'h01, 4);
    wait_wr(wr_b + 1, 20);
    w = wr_cyc[wr_b];
    chk("first_rd_cycle", rd_cyc[rd_b], st + 1);
    chk("first_wr_cycle", w, st + 3);
    inj = 1;
    step(); step();
    chk("dout_hold_in_gap", ioctl_dout, 8'h5C);
    wait_done(dn_b + 1, 100);
    chk("t1_writes", wr_n - wr_b, 4);
    for (int i = 1; i < 4; i++) chk("t1_period", wr_cyc[wr_b + i] - wr_cyc[wr_b + i - 1], 6);
    chk("t1_done_cycle", done_cyc[dn_b], st + 25);
    chk("t1_byte3", wr_data[wr_b + 3], 8'hCB);
    chk("t1_index", ioctl_index, 8'h01);
    step();
    chk("t1_idle_busy", busy, 0);

    // Receiver stall of 10 cycles starting in the second gap cycle.
    go(8'h22, 3);
    wait_wr(wr_b + 1, 20);
    w = wr_cyc[wr_b];
    step();
    ioctl_wait = 1'b1;
    for (int i = 0; i < 10; i++) step();
    ioctl_wait = 1'b0;
    wait_done(dn_b + 1, 100);
    chk("t2_stalled_rd", rd_cyc[rd_b + 1] - w, 14);
    chk("t2_writes", wr_n - wr_b, 3);
    chk("t2_byte2", wr_data[wr_b + 2], 8'hA6);

    // Zero-length transfer.
    step();
    go(8'h77, 0);
    chk("t3_done_now", done, 1);
    chk("t3_busy", busy, 1);
    chk("t3_dl", ioctl_download, 0);
    step(); step();
    chk("t3_done_count", done_n - dn_b, 1);
    chk("t3_done_cycle", done_cyc[dn_b], st + 1);
    chk("t3_no_rd", rd_n - rd_b, 0);
    chk("t3_no_wr", wr_n - wr_b, 0);
    chk("t3_no_dl", dl_n - dl_b, 0);
    chk("t3_busy_after", busy, 0);

    // Second start during an active transfer is ignored.
    go(8'h33, 3);
    wait_wr(wr_b + 1, 20);
    index = 8'h99; length = 25'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(dn_b + 1, 100);
    for (int i = 0; i < 12; i++) step();
    chk("t4_writes", wr_n - wr_b, 3);
    chk("t4_index", ioctl_index, 8'h33);
    chk("t4_done_count", done_n - dn_b, 1);

    // Reset mid-transfer, then reset racing start, then a fresh transfer.
    go(8'h44, 4);
    allow_done = 0;
    wait_wr(wr_b + 2, 40);
    reset = 1'b1;
    step();
    chk_zero("abort");
    reset = 1'b0; xfer_open = 0; pend = 0;
    for (int i = 0; i < 12; i++) step();
    chk("t5_no_done", done_n - dn_b, 0);
    chk("t5_writes", wr_n - wr_b, 2);
    reset = 1'b1; start = 1'b1; index = 8'h66; length = 25'd5;
    step();
    reset = 1'b0; start = 1'b0;
    chk_zero("rst_vs_start");
    step(); step();
    chk("t5_still_idle", busy, 0);
    allow_done = 1;
    go(8'h55, 2);
    wait_done(dn_b + 1, 60);
    chk("t6_writes", wr_n - wr_b, 2);
    chk("t6_byte1", wr_data[wr_b + 1], 8'h81);
    chk("t6_first_rd", rd_cyc[rd_b], st + 1);

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/ioctl_dl_sender.md
IOCTL_DL_SENDER -- requirements
Module: ioctl_dl_sender

Interface
REQ-001 SHALL have parameter WR_GAP, default 3: idle clk_48 cycles after each ioctl_wr pulse before the next fetch (range 1..255).
REQ-002 SHALL have port clk_48, input, 1: sole clock; every register updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: single-cycle request to begin a transfer.
REQ-005 SHALL have port index, input, 8: transfer index, sampled at accepted start.
REQ-006 SHALL have port length, input, 25: byte count, sampled at accepted start.
REQ-007 SHALL have port src_addr, output, 25: byte offset requested from the source.
REQ-008 SHALL have port src_rd, output, 1: single-cycle source read strobe.
REQ-009 SHALL have port src_data, input, 8: source byte, valid when src_valid=1.
REQ-010 SHALL have port src_valid, input, 1: source data-valid.
REQ-011 SHALL have port ioctl_download, output, 1: transfer-active flag.
REQ-012 SHALL have port ioctl_wr, output, 1: one-cycle byte write strobe.
REQ-013 SHALL have port ioctl_addr, output, 25: byte offset of the current write.
REQ-014 SHALL have port ioctl_dout, output, 8: write data.
REQ-015 SHALL have port ioctl_index, output, 8: registered copy of index.
REQ-016 SHALL have port ioctl_wait, input, 1: receiver stall request.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-019 SHALL implement the states IDLE, FETCH, WRITE, GAP and FINISH; all outputs SHALL be registered.
REQ-020 SHALL accept start only in IDLE; in any other state, start SHALL be ignored and index and length SHALL NOT be resampled.
REQ-021 SHALL, on an accepted start with length=0, go IDLE->FINISH: done=1 on the next cycle, ioctl_download never asserted.
REQ-022 SHALL, on an accepted start with length>0, enter FETCH on the next cycle with ioctl_download=1, src_rd=1 for that one cycle, src_addr=0 and ioctl_addr=0.
REQ-023 SHALL, in FETCH, accept src_valid from the src_rd cycle onward, capture src_data into ioctl_dout on the first src_valid, and enter WRITE on the next cycle; src_valid outside FETCH SHALL be ignored.
REQ-024 SHALL hold ioctl_wr=1 for exactly the one WRITE cycle, with ioctl_addr and ioctl_dout stable from that cycle until the next FETCH.
REQ-025 SHALL complete the WRITE cycle even if ioctl_wait=1; WRITE then goes to GAP.
REQ-026 SHALL, in GAP, count WR_GAP cycles, freezing the count while ioctl_wait=1; no src_rd and no ioctl_wr SHALL occur while ioctl_wait=1.
REQ-027 SHALL, at the end of GAP, do one of the following: if bytes remain, increment src_addr and ioctl_addr by 1 and re-enter FETCH with a src_rd pulse; otherwise go to FINISH.
REQ-028 SHALL, in FINISH, drive ioctl_download=0 and done=1 for one cycle, then return to IDLE.
REQ-029 SHALL keep ioctl_download high continuously from the first FETCH through the last GAP cycle.
REQ-030 SHALL use a 25-bit byte counter compared against the sampled length, with no wrap-around inside a transfer.

Reset
REQ-031 SHALL, on the cycle after reset=1, return to IDLE with all outputs 0 and all counters cleared, regardless of state, including mid-transfer.
REQ-032 SHALL NOT produce done when a transfer is aborted by reset; a later start SHALL restart at address 0.
REQ-033 SHALL give reset priority over start when both are asserted in the same cycle.

Verification
REQ-034 length=4, index=8'h01, src_valid 1 cycle after src_rd, WR_GAP=3, wait=0 -> 4 ioctl_wr pulses at addr 0,1,2,3 with source bytes; pulse period 6 cycles; ioctl_index=8'h01; done 1 cycle after the last GAP cycle.
REQ-035 ioctl_wait=1 for 10 cycles starting in the 2nd GAP cycle -> next src_rd delayed by exactly 10 cycles; no ioctl_wr during the stall.
REQ-036 length=0 -> done=1 at T+1; ioctl_download, src_rd and ioctl_wr stay 0.
REQ-037 second start with length=9 during a length=3 transfer -> exactly 3 writes; index and length unchanged.
REQ-038 reset asserted the cycle after the 2nd ioctl_wr -> next cycle all outputs 0, no done; a new start with length=2 -> writes at addr 0 and 1.
REQ-039 src_valid pulsed while in GAP -> ignored; ioctl_dout unchanged.
